// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable modulus, optional saturation,
// synchronous clear, clamped parallel load and a sticky overflow flag.
module counter_updown_mod #(
  parameter int WIDTH    = 8,
  parameter int MOD_VAL  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] In,
  input  logic             E,
  input  logic             D,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             Zero,
  output logic             Ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VAL - 1);
  localparam bit CLAMP_NEEDED = (longint'(MOD_VAL) < (longint'(1) << WIDTH));

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_qNext;
  logic             w_ovfNext;
  logic [WIDTH-1:0] w_loadVal;
  logic             w_atMax;
  logic             w_atZero;

  assign w_atMax  = (r_q == MAX);
  assign w_atZero = (r_q == '0);

  // A full-range modulus cannot see an out-of-range load, so no comparator is built.
  generate
    if (CLAMP_NEEDED) begin : g_clamp
      assign w_loadVal = (In > MAX) ? MAX : In;
    end else begin : g_noClamp
      assign w_loadVal = In;
    end
  endgenerate

  always_comb begin
    w_qNext   = r_q;
    w_ovfNext = r_ovf;
    if (Clr) begin
      w_qNext   = '0;
      w_ovfNext = 1'b0;
    end else if (Load) begin
      w_qNext = w_loadVal;
    end else if (E) begin
      if (D) begin
        if (w_atMax) begin
          w_qNext   = SATURATE ? MAX : '0;
          w_ovfNext = 1'b1;
        end else begin
          w_qNext = r_q + WIDTH'(1);
        end
      end else begin
        if (w_atZero) begin
          w_qNext   = SATURATE ? '0 : MAX;
          w_ovfNext = 1'b1;
        end else begin
          w_qNext = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_qNext;
      r_ovf <= w_ovfNext;
    end
  end

  // Carry-out stays combinational so cascaded stages ripple within one cycle.
  assign Cout = E & ~Load & ~Clr & ((D & w_atMax) | (~D & w_atZero));
  assign Zero = w_atZero;
  assign Q    = r_q;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: vector table, corner sequences,
// a two-stage cascade and randomized runs against an arithmetic model.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Instance A: default 8-bit, modulus 256, wrapping
  logic       aRst_n, aClr, aLoad, aE, aD, aCout, aZero, aOvf;
  logic [7:0] aIn, aQ;
  counter_updown_mod #(.WIDTH(8), .MOD_VAL(256), .SATURATE(0)) dutA (
    .Clk(clk), .Rst_n(aRst_n), .Clr(aClr), .Load(aLoad), .In(aIn), .E(aE), .D(aD),
    .Q(aQ), .Cout(aCout), .Zero(aZero), .Ovf(aOvf));

  // Instance B: 4-bit, modulus 10, wrapping
  logic       bRst_n, bClr, bLoad, bE, bD, bCout, bZero, bOvf;
  logic [3:0] bIn, bQ;
  counter_updown_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(0)) dutB (
    .Clk(clk), .Rst_n(bRst_n), .Clr(bClr), .Load(bLoad), .In(bIn), .E(bE), .D(bD),
    .Q(bQ), .Cout(bCout), .Zero(bZero), .Ovf(bOvf));

  // Instance C: 4-bit, modulus 16, saturating
  logic       cRst_n, cClr, cLoad, cE, cD, cCout, cZero, cOvf;
  logic [3:0] cIn, cQ;
  counter_updown_mod #(.WIDTH(4), .MOD_VAL(16), .SATURATE(1)) dutC (
    .Clk(clk), .Rst_n(cRst_n), .Clr(cClr), .Load(cLoad), .In(cIn), .E(cE), .D(cD),
    .Q(cQ), .Cout(cCout), .Zero(cZero), .Ovf(cOvf));

  // Cascade: low stage carry-out enables the high stage
  logic       kRst_n, kE;
  logic       lCout, lZero, lOvf, hCout, hZero, hOvf;
  logic [3:0] lQ, hQ;
  counter_updown_mod #(.WIDTH(4), .MOD_VAL(16), .SATURATE(0)) dutLow (
    .Clk(clk), .Rst_n(kRst_n), .Clr(1'b0), .Load(1'b0), .In(4'h0), .E(kE), .D(1'b1),
    .Q(lQ), .Cout(lCout), .Zero(lZero), .Ovf(lOvf));
  counter_updown_mod #(.WIDTH(4), .MOD_VAL(16), .SATURATE(0)) dutHigh (
    .Clk(clk), .Rst_n(kRst_n), .Clr(1'b0), .Load(1'b0), .In(4'h0), .E(lCout), .D(1'b1),
    .Q(hQ), .Cout(hCout), .Zero(hZero), .Ovf(hOvf));

  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] inVal;
    logic       e;
    logic       d;
    logic       expCout;
    logic [7:0] expQ;
    logic       expOvf;
    logic       expZero;
  } vecT;

  vecT vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic clr, input logic load, input logic [7:0] inVal,
                               input logic e, input logic d);
    aClr = clr; aLoad = load; aIn = inVal; aE = e; aD = d;
  endtask

  task automatic stepB(input logic clr, input logic load, input logic [3:0] inVal,
                       input logic e, input logic d);
    @(negedge clk);
    bClr = clr; bLoad = load; bIn = inVal; bE = e; bD = d;
  endtask

  task automatic stepC(input logic clr, input logic load, input logic [3:0] inVal,
                       input logic e, input logic d);
    @(negedge clk);
    cClr = clr; cLoad = load; cIn = inVal; cE = e; cD = d;
  endtask

  // Reference model: counting is plain modular or clamped integer arithmetic.
  int mbQ, mbOvf, mcQ, mcOvf;

  initial begin
    // clr, load, in, e, d, expCout | expQ, expOvf, expZero (after the edge)
    vecs[0]  = '{1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};

    aRst_n = 1'b0; bRst_n = 1'b0; cRst_n = 1'b0; kRst_n = 1'b0; kE = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    bClr = 0; bLoad = 0; bIn = 0; bE = 0; bD = 0;
    cClr = 0; cLoad = 0; cIn = 0; cE = 0; cD = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetQ", aQ, 8'h00);
    checkOutput("resetOvf", aOvf, 1'b0);
    checkOutput("resetZero", aZero, 1'b1);
    @(negedge clk);
    aRst_n = 1'b1; bRst_n = 1'b1; cRst_n = 1'b1; kRst_n = 1'b1;

    // Table-driven vectors on the default instance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].clr, vecs[i].load, vecs[i].inVal, vecs[i].e, vecs[i].d);
      #1;
      checkOutput($sformatf("vec%0d cout", i), aCout, vecs[i].expCout);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d q", i), aQ, vecs[i].expQ);
      checkOutput($sformatf("vec%0d ovf", i), aOvf, vecs[i].expOvf);
      checkOutput($sformatf("vec%0d zero", i), aZero, vecs[i].expZero);
    end

    // Asynchronous reset mid-count with Ovf set, then Clr/Load/E priority
    @(negedge clk); applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    @(negedge clk); applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    checkOutput("preRstQ", aQ, 8'h37);
    checkOutput("preRstOvf", aOvf, 1'b1);
    #1 aRst_n = 1'b0;
    #1;
    checkOutput("asyncRstQ", aQ, 8'h00);
    checkOutput("asyncRstOvf", aOvf, 1'b0);
    checkOutput("asyncRstZero", aZero, 1'b1);
    @(negedge clk); aRst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
    @(negedge clk); applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("clrPriorityQ", aQ, 8'h00);

    // Modulo-10 down-count wrap and load clamp
    stepB(0, 1, 4'd1, 0, 0);
    stepB(0, 0, 4'd0, 1, 0); #1 checkOutput("modDown1 cout", bCout, 1'b0);
    @(posedge clk); #1 checkOutput("modDown1 q", bQ, 4'd0);
    stepB(0, 0, 4'd0, 1, 0); #1 checkOutput("modDown2 cout", bCout, 1'b1);
    @(posedge clk); #1 checkOutput("modDown2 q", bQ, 4'd9);
    checkOutput("modDown2 ovf", bOvf, 1'b1);
    stepB(0, 0, 4'd0, 1, 0); #1 checkOutput("modDown3 cout", bCout, 1'b0);
    @(posedge clk); #1 checkOutput("modDown3 q", bQ, 4'd8);
    stepB(0, 1, 4'd12, 1, 1);
    @(posedge clk); #1 checkOutput("modClamp q", bQ, 4'd9);
    stepB(0, 0, 4'd0, 1, 1); #1 checkOutput("modUp cout", bCout, 1'b1);
    @(posedge clk); #1 checkOutput("modUp q", bQ, 4'd0);

    // Saturating counter holds at the terminal values
    stepC(0, 1, 4'd14, 0, 1);
    stepC(0, 0, 4'd0, 1, 1);
    @(posedge clk); #1 checkOutput("sat1 q", cQ, 4'd15);
    checkOutput("sat1 ovf", cOvf, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1 checkOutput($sformatf("sat%0d cout", i), cCout, 1'b1);
      @(posedge clk); #1 checkOutput($sformatf("sat%0d q", i), cQ, 4'd15);
      checkOutput($sformatf("sat%0d ovf", i), cOvf, 1'b1);
    end
    stepC(0, 0, 4'd0, 1, 0);
    @(posedge clk); #1 checkOutput("satDown q", cQ, 4'd14);
    stepC(1, 0, 4'd0, 0, 0);
    stepC(0, 0, 4'd0, 1, 0);
    @(posedge clk); #1 checkOutput("satZero q", cQ, 4'd0);
    checkOutput("satZero ovf", cOvf, 1'b1);

    // Two-stage cascade, 20 enabled cycles
    @(negedge clk); kE = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1 checkOutput($sformatf("casc%0d lowCout", n), lCout, ((n % 16) == 15) ? 1'b1 : 1'b0);
      @(posedge clk); #1 checkOutput($sformatf("casc%0d value", n), {hQ, lQ}, n + 1);
      @(negedge clk);
    end
    kE = 1'b0;
    checkOutput("cascFinal", {hQ, lQ}, 8'h14);

    // Randomized run on instances B and C against the arithmetic model
    stepB(1, 0, 0, 0, 0); stepC(1, 0, 0, 0, 0);
    @(posedge clk);
    mbQ = 0; mbOvf = 0; mcQ = 0; mcOvf = 0;
    for (int n = 0; n < 400; n++) begin
      logic rbClr, rbLoad, rbE, rbD, rcClr, rcLoad, rcE, rcD;
      logic [3:0] rbIn, rcIn;
      int expBCout, expCCout;
      rbClr = ($urandom_range(0, 19) == 0); rbLoad = ($urandom_range(0, 7) == 0);
      rbE = ($urandom_range(0, 3) != 0); rbD = $urandom_range(0, 1); rbIn = 4'($urandom);
      rcClr = ($urandom_range(0, 19) == 0); rcLoad = ($urandom_range(0, 7) == 0);
      rcE = ($urandom_range(0, 3) != 0); rcD = $urandom_range(0, 1); rcIn = 4'($urandom);
      @(negedge clk);
      bClr = rbClr; bLoad = rbLoad; bIn = rbIn; bE = rbE; bD = rbD;
      cClr = rcClr; cLoad = rcLoad; cIn = rcIn; cE = rcE; cD = rcD;
      expBCout = (rbE && !rbLoad && !rbClr && ((rbD && mbQ == 9) || (!rbD && mbQ == 0))) ? 1 : 0;
      expCCout = (rcE && !rcLoad && !rcClr && ((rcD && mcQ == 15) || (!rcD && mcQ == 0))) ? 1 : 0;
      #1;
      checkOutput($sformatf("rndB%0d cout", n), bCout, expBCout);
      checkOutput($sformatf("rndC%0d cout", n), cCout, expCCout);
      if (rbClr) begin mbQ = 0; mbOvf = 0; end
      else if (rbLoad) mbQ = (rbIn > 9) ? 9 : int'(rbIn);
      else if (rbE) begin
        if (rbD) begin if (mbQ == 9) mbOvf = 1; mbQ = (mbQ + 1) % 10; end
        else begin if (mbQ == 0) mbOvf = 1; mbQ = (mbQ + 9) % 10; end
      end
      if (rcClr) begin mcQ = 0; mcOvf = 0; end
      else if (rcLoad) mcQ = int'(rcIn);
      else if (rcE) begin
        if (rcD) begin if (mcQ == 15) mcOvf = 1; mcQ = (mcQ < 15) ? mcQ + 1 : 15; end
        else begin if (mcQ == 0) mcOvf = 1; mcQ = (mcQ > 0) ? mcQ - 1 : 0; end
      end
      @(posedge clk); #1;
      checkOutput($sformatf("rndB%0d q", n), bQ, mbQ);
      checkOutput($sformatf("rndB%0d ovf", n), bOvf, mbOvf);
      checkOutput($sformatf("rndB%0d zero", n), bZero, (mbQ == 0) ? 1 : 0);
      checkOutput($sformatf("rndC%0d q", n), cQ, mcQ);
      checkOutput($sformatf("rndC%0d ovf", n), cOvf, mcOvf);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised synchronous up/down counter. Successor to the fixed 8-bit loadable counter.
- Adds run-time direction, programmable modulus, optional saturation, a synchronous clear, and a sticky overflow flag.
- Used as a building block for timers, address generators and prescalers. Cascadable through Cout into the E input of the next stage.

Parameters:
- WIDTH, 8, counter width in bits (must be >= 1).
- MOD_VAL, 256, count modulus. Q ranges over 0..MOD_VAL-1. Legal range 2 <= MOD_VAL <= 2**WIDTH.
- SATURATE, 0, terminal-count behaviour. 0 = wrap around; 1 = hold at the terminal value.

Ports:
- Clk, input, 1, clock, rising edge.
- Rst_n, input, 1, asynchronous active-low reset.
- Clr, input, 1, synchronous clear to 0.
- Load, input, 1, synchronous parallel load of In.
- In, input, WIDTH, parallel load value.
- E, input, 1, count enable (carry-in from the previous stage).
- D, input, 1, direction. 1 = count up, 0 = count down.
- Q, output, WIDTH, registered count value.
- Cout, output, 1, combinational terminal-count / carry-out for cascading.
- Zero, output, 1, combinational flag, 1 when Q == 0.
- Ovf, output, 1, registered sticky flag: a wrap or saturation event has occurred.

Behaviour:
- MAX = MOD_VAL-1.
- Rst_n low, asynchronously and at any time (including mid-count): Q = 0, Ovf = 0. Cout and Zero then follow from Q = 0, so Zero = 1.
- Per-edge priority, highest first: Clr > Load > E. With none of them asserted, Q holds.
- Clr = 1: Q <= 0, Ovf <= 0. Clr overrides Load and E in the same cycle.
- Load = 1 (Clr = 0): Q <= In if In <= MAX, otherwise Q <= MAX (clamped).
  - Ovf is unchanged.
  - E is ignored that cycle.
  - Cout is forced to 0 while Load = 1.
- E = 1, D = 1 (count up):
  - Q < MAX: Q <= Q+1.
  - Q == MAX, SATURATE = 0: Q <= 0 and Ovf <= 1.
  - Q == MAX, SATURATE = 1: Q holds at MAX and Ovf <= 1.
- E = 1, D = 0 (count down):
  - Q > 0: Q <= Q-1.
  - Q == 0, SATURATE = 0: Q <= MAX and Ovf <= 1.
  - Q == 0, SATURATE = 1: Q holds at 0 and Ovf <= 1.
- Latency: one clock from Clr/Load/E sampled at the edge to the new Q.
- Cout = E & ~Load & ~Clr & ((D & Q == MAX) | (~D & Q == 0)). Cout is purely combinational so a chain of stages ripples in one cycle.
- Zero = (Q == 0), combinational. It is independent of E.
- Ovf stays set until Clr or reset. Load does not clear it.
- Changing D mid-count takes effect on the next enabled edge. There is no lost or duplicated count.
- Arithmetic is in WIDTH bits. For MOD_VAL < 2**WIDTH, values above MAX are reachable only through a Load, which clamps them, so Q never exceeds MAX.
- Implementation is a single registered state with next-state logic. Wrap detection compares against MAX and does not rely on native overflow.

Test Plan:
- Reset/priority: Rst_n low mid-count at Q=0x37 → Q=0, Ovf=0, Zero=1 immediately (before the next edge). Then Clr=1, Load=1, In=0x55, E=1 on the same edge → Q=0.
- Up-wrap, defaults (WIDTH=8, MOD_VAL=256): Load In=0xFE, then E=1, D=1 for 3 cycles → Q=0xFF (Cout=1), 0x00 (Ovf=1, Zero=1), 0x01. Ovf stays 1 until Clr.
- Modulo down, WIDTH=4, MOD_VAL=10: from Q=1, E=1, D=0 for 3 cycles → Q=0 (Cout=1), then 9 (Ovf=1), then 8. Load In=12 → Q=9 (clamped).
- Saturate, WIDTH=4, MOD_VAL=16, SATURATE=1: Load 14, count up 4 cycles → 15, 15, 15, 15 with Ovf=1. D=0 for 1 cycle → 14.
- Cascade: two WIDTH=4 instances, low stage's Cout driving the high stage's E, D=1, 20 enabled cycles from 0x00 → combined value 0x14. Low Cout is high exactly on cycles where low Q=0xF.
- Load/E interaction: E=1, Load=1, In=0x10 → Q=0x10 (no increment) and Cout=0 during the load cycle.
